// File: rtl/int_decl_gen.sv
// Streams one C-style declaration "int a0,b0,...;" a character at a time over a valid/ready handshake.
// Optional macro INTGEN_COMMA_SPACE_EN inserts a space after every comma.
module int_decl_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] id_count,
  input  logic [2:0] id_len,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KW    = 3'd1,
    SEP   = 3'd2,
    ID    = 3'd3,
    COMMA = 3'd4,
`ifdef INTGEN_COMMA_SPACE_EN
    CSPC  = 3'd5,
`endif
    SEMI  = 3'd6,
    FIN   = 3'd7
  } state_t;

  state_t     state_r, state_s;
  logic [1:0] kw_idx_r, kw_idx_s;
  logic [2:0] id_cnt_r, id_cnt_s;
  logic [2:0] ch_idx_r, ch_idx_s;
  logic [2:0] n_r, n_s;
  logic [2:0] l_r, l_s;
  logic       accept_s;

  // Character offered in a given state; identifier chars are letter then ascending digits.
  function automatic logic [7:0] char_of(input state_t st, input logic [1:0] kw,
                                         input logic [2:0] id, input logic [2:0] ch);
    logic [7:0] c;
    case (st)
      KW: begin
        case (kw)
          2'd0:    c = 8'h69;
          2'd1:    c = 8'h6e;
          2'd2:    c = 8'h74;
          default: c = 8'h00;
        endcase
      end
      SEP:   c = 8'h20;
      ID: begin
        if (ch == 3'd0) c = 8'h61 + {5'd0, id};
        else            c = 8'h30 + {5'd0, ch - 3'd1};
      end
      COMMA: c = 8'h2c;
`ifdef INTGEN_COMMA_SPACE_EN
      CSPC:  c = 8'h20;
`endif
      SEMI:  c = 8'h3b;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // States in which a character is being offered.
  function automatic logic valid_of(input state_t st);
    logic v;
    case (st)
      IDLE:    v = 1'b0;
      FIN:     v = 1'b0;
      default: v = 1'b1;
    endcase
    return v;
  endfunction

  assign accept_s = out_valid & out_ready;

  // Next-state and counter logic; everything holds unless a character is accepted.
  always_comb begin
    state_s  = state_r;
    kw_idx_s = kw_idx_r;
    id_cnt_s = id_cnt_r;
    ch_idx_s = ch_idx_r;
    n_s      = n_r;
    l_s      = l_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          n_s      = (id_count == 3'd0) ? 3'd1 : id_count;
          l_s      = (id_len == 3'd0) ? 3'd1 : id_len;
          kw_idx_s = 2'd0;
          id_cnt_s = 3'd0;
          ch_idx_s = 3'd0;
          state_s  = KW;
        end else begin
          state_s = IDLE;
        end
      end
      KW: begin
        if (accept_s) begin
          if (kw_idx_r == 2'd2) state_s  = SEP;
          else                  kw_idx_s = kw_idx_r + 2'd1;
        end else begin
          state_s = KW;
        end
      end
      SEP: begin
        if (accept_s) begin
          id_cnt_s = 3'd0;
          ch_idx_s = 3'd0;
          state_s  = ID;
        end else begin
          state_s = SEP;
        end
      end
      ID: begin
        if (accept_s) begin
          if (ch_idx_r == l_r - 3'd1) begin
            if (id_cnt_r == n_r - 3'd1) state_s = SEMI;
            else                        state_s = COMMA;
          end else begin
            ch_idx_s = ch_idx_r + 3'd1;
          end
        end else begin
          state_s = ID;
        end
      end
      COMMA: begin
        if (accept_s) begin
`ifdef INTGEN_COMMA_SPACE_EN
          state_s  = CSPC;
`else
          id_cnt_s = id_cnt_r + 3'd1;
          ch_idx_s = 3'd0;
          state_s  = ID;
`endif
        end else begin
          state_s = COMMA;
        end
      end
`ifdef INTGEN_COMMA_SPACE_EN
      CSPC: begin
        if (accept_s) begin
          id_cnt_s = id_cnt_r + 3'd1;
          ch_idx_s = 3'd0;
          state_s  = ID;
        end else begin
          state_s = CSPC;
        end
      end
`endif
      SEMI: begin
        if (accept_s) state_s = FIN;
        else          state_s = SEMI;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters and latched sizes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      kw_idx_r <= 2'd0;
      id_cnt_r <= 3'd0;
      ch_idx_r <= 3'd0;
      n_r      <= 3'd0;
      l_r      <= 3'd0;
    end else begin
      state_r  <= state_s;
      kw_idx_r <= kw_idx_s;
      id_cnt_r <= id_cnt_s;
      ch_idx_r <= ch_idx_s;
      n_r      <= n_s;
      l_r      <= l_s;
    end
  end

  // Outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out       <= char_of(state_s, kw_idx_s, id_cnt_s, ch_idx_s);
      out_valid <= valid_of(state_s);
      busy      <= (state_s != IDLE);
      done      <= (state_s == FIN);
    end
  end

endmodule

// File: tb/tb_int_decl_gen.sv
// Self-checking bench for int_decl_gen: directed table, reset abort sequence and randomized runs.
module tb_int_decl_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] id_count;
  logic [2:0] id_len;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  byte unsigned exp_q[$];

  typedef struct {
    int n;
    int l;
    int mode;   // 0: ready high, 1: ready toggles, 2: random ready
    bit inject; // extra start pulse while busy
  } vec_t;

  vec_t  tbl[5];
  string tbl_exp[5];

  int_decl_gen dut (
    .clk(clk), .reset(reset), .start(start), .id_count(id_count), .id_len(id_len),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input bit ok, input string name, input int act, input int req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic void chk_str(input string name, input string act, input string req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
    end
  endfunction

  // Reference: the declaration text built directly from the character rules.
  function automatic void build_exp(input int n, input int l);
    int nn = (n == 0) ? 1 : n;
    int ll = (l == 0) ? 1 : l;
    string kw = "int ";
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(kw[i]);
    for (int k = 0; k < nn; k++) begin
      if (k > 0) begin
        exp_q.push_back(8'h2c);
`ifdef INTGEN_COMMA_SPACE_EN
        exp_q.push_back(8'h20);
`endif
      end
      exp_q.push_back(8'(97 + k));
      for (int j = 0; j < ll - 1; j++) exp_q.push_back(8'(48 + j));
    end
    exp_q.push_back(8'h3b);
  endfunction

  function automatic int formula_len(input int n, input int l);
    int nn = (n == 0) ? 1 : n;
    int ll = (l == 0) ? 1 : l;
    int len = 5 + nn * ll + (nn - 1);
`ifdef INTGEN_COMMA_SPACE_EN
    len = len + (nn - 1);
`endif
    return len;
  endfunction

  task automatic run_decl(input int n, input int l, input int mode, input bit inject,
                          input string texp, input bit use_tbl);
    byte unsigned got[$];
    string gs = "";
    int busy_cyc = 0;
    int dones = 0;
    int cyc = 0;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [7:0] po = 8'h00;
    bit fin = 1'b0;
    build_exp(n, l);
    @(negedge clk);
    start = 1'b1; id_count = 3'(n); id_len = 3'(l); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; id_count = 3'($urandom); id_len = 3'($urandom);
    chk(out_valid == 1'b1 && out == 8'h69, "first_char", int'(out), 8'h69);
    while (!fin && cyc < 400) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc % 2 == 0);
      else                out_ready = 1'($urandom_range(0, 1));
      if (inject && cyc == 3) begin
        start = 1'b1; id_count = 3'd7; id_len = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (pv && !pr) chk(out_valid == 1'b1 && out == po, "stall_stable", int'(out), int'(po));
      if (!out_valid) chk(out == 8'h00, "idle_out_zero", int'(out), 0);
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      if (out_valid && out_ready) got.push_back(out);
      pv = out_valid; pr = out_ready; po = out;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk(fin, "done_timeout", cyc, 400);
    chk(busy == 1'b0 && done == 1'b0, "idle_after_fin", {30'd0, busy, done}, 0);
    chk(dones == 1, "done_count", dones, 1);
    chk(got.size() == exp_q.size(), "char_count_model", got.size(), exp_q.size());
    chk(got.size() == formula_len(n, l), "char_count_formula", got.size(), formula_len(n, l));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(got[i] == exp_q[i], $sformatf("char[%0d]", i), int'(got[i]), int'(exp_q[i]));
    foreach (got[i]) gs = $sformatf("%s%c", gs, got[i]);
    if (use_tbl) chk_str("stream_text", gs, texp);
    if (mode == 0) chk(busy_cyc == exp_q.size() + 1, "busy_span", busy_cyc, exp_q.size() + 1);
  endtask

  initial begin
    string part;
    int acc;
    tbl[0] = '{n: 1, l: 1, mode: 0, inject: 1'b0};
    tbl[1] = '{n: 3, l: 2, mode: 0, inject: 1'b0};
    tbl[2] = '{n: 0, l: 0, mode: 0, inject: 1'b0};
    tbl[3] = '{n: 2, l: 3, mode: 1, inject: 1'b0};
    tbl[4] = '{n: 2, l: 2, mode: 0, inject: 1'b1};
    tbl_exp[0] = "int a;";
    tbl_exp[2] = "int a;";
`ifdef INTGEN_COMMA_SPACE_EN
    tbl_exp[1] = "int a0, b0, c0;";
    tbl_exp[3] = "int a01, b01;";
    tbl_exp[4] = "int a0, b0;";
`else
    tbl_exp[1] = "int a0,b0,c0;";
    tbl_exp[3] = "int a01,b01;";
    tbl_exp[4] = "int a0,b0;";
`endif

    reset = 1'b0; start = 1'b0; id_count = 3'd0; id_len = 3'd0; out_ready = 1'b1;
    #1;
    chk(out == 8'h00 && out_valid == 1'b0, "reset_out", int'(out), 0);
    chk(busy == 1'b0 && done == 1'b0, "reset_flags", {30'd0, busy, done}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++)
      run_decl(tbl[i].n, tbl[i].l, tbl[i].mode, tbl[i].inject, tbl_exp[i], 1'b1);

    // Abort after "int a" has been accepted.
    @(negedge clk);
    start = 1'b1; id_count = 3'd1; id_len = 3'd1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    part = "";
    acc = 0;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      if (out_valid && out_ready) begin
        part = $sformatf("%s%c", part, out);
        acc++;
      end
      if (acc < 5) @(negedge clk);
    end
    chk_str("pre_reset_text", part, "int a");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk(out == 8'h00 && out_valid == 1'b0, "abort_out", int'(out), 0);
    chk(busy == 1'b0 && done == 1'b0, "abort_flags", {30'd0, busy, done}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk(done == 1'b0 && out_valid == 1'b0, "abort_no_done", {30'd0, done, out_valid}, 0);
    end
    reset = 1'b1;
    run_decl(1, 1, 0, 1'b0, "int a;", 1'b1);

    for (int i = 0; i < 20; i++)
      run_decl($urandom_range(0, 7), $urandom_range(0, 7), 2, 1'($urandom_range(0, 1)), "", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
